rst_on_lut_8bit_serializer: RTL and testbench

- Downstream consumer of the 8-bit reset-gated LUT stage.
- Takes the parallel word out0..out7, which arrives as din[7:0] and is already forced to 0 while rst is high.
- Shifts the word out one bit per accepted beat over a valid/ready serial port.
- Reports word parity, a done pulse and a wrapping count of completed words.
- Micro-benchmark block: it exercises the reset net as both an async flop reset and a datapath-related signal in the same fabric.

---
 rtl/rst_on_lut_8bit_serializer.sv | 84 ++++++++
 tb/tb_rst_on_lut_8bit_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_on_lut_8bit_serializer.sv
// Serializer for the reset-gated LUT word: loads din, shifts it out over a
// valid/ready port, and reports parity, a done pulse and a wrapping word count.
//
// state | meaning
// IDLE  | waiting for din_valid; din_ready high
// SHIFT | presenting shreg bits on sout; advances on sout_ready
module rst_on_lut_8bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             parity,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;

  assign din_ready  = (state == IDLE);
  assign sout_valid = (state == SHIFT);
  // sout is forced low outside SHIFT so the leftover final bit never leaks in IDLE
  assign sout       = sout_valid & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign sout_last  = sout_valid & (bit_cnt == LAST_BIT);

  always_comb begin
    shreg_next = shreg;
    if (LSB_FIRST) shreg_next = {1'b0, shreg[WIDTH-1:1]};
    else           shreg_next = {shreg[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            shreg   <= din;
            parity  <= ^din;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (sout_last) begin
              state    <= IDLE;
              done     <= 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              shreg   <= shreg_next;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_on_lut_8bit_serializer.sv
// Directed bench for rst_on_lut_8bit_serializer: LSB-first, MSB-first with
// backpressure, back-to-back loads, mid-word reset and a 2-bit counter wrap.
module tb_rst_on_lut_8bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: defaults (LSB first, 8-bit count)
  logic [7:0] din_a = '0;
  logic       dv_a = 1'b0, sr_a = 1'b0;
  logic       drdy_a, sout_a, sval_a, slast_a, par_a, done_a;
  logic [7:0] cnt_a;

  // instance m: MSB first
  logic [7:0] din_m = '0;
  logic       dv_m = 1'b0, sr_m = 1'b0;
  logic       drdy_m, sout_m, sval_m, slast_m, par_m, done_m;
  logic [7:0] cnt_m;

  // instance w: 2-bit word counter
  logic [7:0] din_w = '0;
  logic       dv_w = 1'b0, sr_w = 1'b0;
  logic       drdy_w, sout_w, sval_w, slast_w, par_w, done_w;
  logic [1:0] cnt_w;

  rst_on_lut_8bit_serializer dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(drdy_a),
    .sout(sout_a), .sout_valid(sval_a), .sout_ready(sr_a), .sout_last(slast_a),
    .parity(par_a), .done(done_a), .word_cnt(cnt_a)
  );

  rst_on_lut_8bit_serializer #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(drdy_m),
    .sout(sout_m), .sout_valid(sval_m), .sout_ready(sr_m), .sout_last(slast_m),
    .parity(par_m), .done(done_m), .word_cnt(cnt_m)
  );

  rst_on_lut_8bit_serializer #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .din(din_w), .din_valid(dv_w), .din_ready(drdy_w),
    .sout(sout_w), .sout_valid(sval_w), .sout_ready(sr_w), .sout_last(slast_w),
    .parity(par_w), .done(done_w), .word_cnt(cnt_w)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] w_words [5];
    logic       w_par [5];
    logic       held;

    // reset held with random traffic on the inputs
    for (int i = 0; i < 4; i++) begin
      din_a = 8'($urandom);
      dv_a  = 1'($urandom_range(0, 1));
      sr_a  = 1'($urandom_range(0, 1));
      tick();
      chk("rst_din_ready", 32'(drdy_a), 32'd1);
      chk("rst_sout_valid", 32'(sval_a), 32'd0);
      chk("rst_sout", 32'(sout_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_word_cnt", 32'(cnt_a), 32'd0);
    end
    dv_a = 1'b0; sr_a = 1'b0;
    rst = 1'b0;
    tick();

    // LSB-first A5 with sink always ready
    din_a = 8'hA5; dv_a = 1'b1; sr_a = 1'b1;
    tick();
    dv_a = 1'b0;
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_sout", 32'(sout_a), 32'(bits[i]));
      chk("lsb_sout_valid", 32'(sval_a), 32'd1);
      chk("lsb_sout_last", 32'(slast_a), 32'(i == 7));
      chk("lsb_parity", 32'(par_a), 32'd0);
      chk("lsb_done_early", 32'(done_a), 32'd0);
      tick();
    end
    chk("lsb_done", 32'(done_a), 32'd1);
    chk("lsb_word_cnt", 32'(cnt_a), 32'd1);
    chk("lsb_idle_ready", 32'(drdy_a), 32'd1);
    tick();
    chk("lsb_done_one_cycle", 32'(done_a), 32'd0);
    chk("lsb_parity_held", 32'(par_a), 32'd0);
    sr_a = 1'b0;

    // MSB-first 81 with a stall before every accepted beat
    din_m = 8'h81; dv_m = 1'b1; sr_m = 1'b0;
    tick();
    dv_m = 1'b0;
    bits = 8'h81;
    for (int b = 0; b < 8; b++) begin
      sr_m = 1'b0;
      chk("msb_sout", 32'(sout_m), 32'(bits[7-b]));
      chk("msb_sout_last", 32'(slast_m), 32'(b == 7));
      held = sout_m;
      tick();
      chk("msb_stall_sout", 32'(sout_m), 32'(bits[7-b]));
      chk("msb_stall_valid", 32'(sval_m), 32'd1);
      chk("msb_stall_last", 32'(slast_m), 32'(b == 7));
      chk("msb_stall_done", 32'(done_m), 32'd0);
      sr_m = 1'b1;
      tick();
    end
    sr_m = 1'b0;
    chk("msb_done", 32'(done_m), 32'd1);
    chk("msb_word_cnt", 32'(cnt_m), 32'd1);
    chk("msb_parity", 32'(par_m), 32'd0);

    // back-to-back: 01 then 03 with din_valid held high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    din_a = 8'h01; dv_a = 1'b1; sr_a = 1'b1;
    tick();
    din_a = 8'h03;
    bits = 8'h01;
    chk("b2b_parity1", 32'(par_a), 32'd1);
    for (int n = 0; n < 8; n++) begin
      chk("b2b_sout1", 32'(sout_a), 32'(bits[n]));
      chk("b2b_busy1", 32'(drdy_a), 32'd0);
      tick();
    end
    chk("b2b_done1", 32'(done_a), 32'd1);
    chk("b2b_cnt1", 32'(cnt_a), 32'd1);
    chk("b2b_idle_gap", 32'(sval_a), 32'd0);
    tick();
    dv_a = 1'b0;
    chk("b2b_second_load", 32'(sval_a), 32'd1);
    chk("b2b_parity2", 32'(par_a), 32'd0);
    chk("b2b_done_low", 32'(done_a), 32'd0);
    bits = 8'h03;
    for (int n = 0; n < 8; n++) begin
      chk("b2b_sout2", 32'(sout_a), 32'(bits[n]));
      tick();
    end
    chk("b2b_done2", 32'(done_a), 32'd1);
    chk("b2b_cnt2", 32'(cnt_a), 32'd2);

    // reset three beats into an FF word
    din_a = 8'hFF; dv_a = 1'b1;
    tick();
    dv_a = 1'b0;
    tick(); tick(); tick();
    chk("mid_pre_valid", 32'(sval_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 32'(sval_a), 32'd0);
    chk("mid_async_ready", 32'(drdy_a), 32'd1);
    chk("mid_async_cnt", 32'(cnt_a), 32'd0);
    chk("mid_async_sout", 32'(sout_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_done", 32'(done_a), 32'd0);
    chk("mid_cnt_after", 32'(cnt_a), 32'd0);
    din_a = 8'h0F; dv_a = 1'b1;
    tick();
    dv_a = 1'b0;
    bits = 8'h0F;
    chk("mid_parity", 32'(par_a), 32'd0);
    for (int n = 0; n < 8; n++) begin
      chk("mid_sout", 32'(sout_a), 32'(bits[n]));
      tick();
    end
    chk("mid_done", 32'(done_a), 32'd1);
    chk("mid_cnt", 32'(cnt_a), 32'd1);
    sr_a = 1'b0;

    // 2-bit counter wrap over five words, including an all-zero word
    w_words[0] = 8'h00; w_par[0] = 1'b0;
    w_words[1] = 8'h01; w_par[1] = 1'b1;
    w_words[2] = 8'h07; w_par[2] = 1'b1;
    w_words[3] = 8'hF0; w_par[3] = 1'b0;
    w_words[4] = 8'h7F; w_par[4] = 1'b1;
    sr_w = 1'b1;
    for (int w = 0; w < 5; w++) begin
      din_w = w_words[w]; dv_w = 1'b1;
      tick();
      dv_w = 1'b0;
      chk("wrap_parity", 32'(par_w), 32'(w_par[w]));
      for (int n = 0; n < 7; n++) begin
        chk("wrap_done_early", 32'(done_w), 32'd0);
        tick();
      end
      chk("wrap_last", 32'(slast_w), 32'd1);
      tick();
      chk("wrap_done", 32'(done_w), 32'd1);
      chk("wrap_cnt", 32'(cnt_w), 32'((w + 1) % 4));
      tick();
      chk("wrap_done_pulse", 32'(done_w), 32'd0);
    end
    sr_w = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
